// File: rtl/bht_ctrl.sv
// Branch history table controller: 2-bit counters, IF lookup, EX update.
// Optional gshare indexing when GSHARE_EN is defined.
module bht_ctrl #(
    parameter int         IDX_BITS = 6,
    parameter int         PC_LSB   = 2,
    parameter logic [1:0] INIT_VAL = 2'b01
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        lookup_valid,
    input  logic [31:0] lookup_pc,
    output logic        pred_valid,
    output logic        pred_taken,
    input  logic        upd_valid,
    input  logic [31:0] upd_pc,
    input  logic        upd_taken,
    output logic        ready
);

    localparam int N = 1 << IDX_BITS;

    typedef enum logic {
        S_INIT,
        S_RUN
    } state_t;

    state_t              state_q;
    state_t              state_d;
    logic [IDX_BITS-1:0] init_ptr;
    logic [1:0]          cnt_tbl [N];
    logic                u1_valid;
    logic                u1_taken;
    logic [IDX_BITS-1:0] u1_idx;
    logic [IDX_BITS-1:0] lk_idx;
    logic [IDX_BITS-1:0] up_idx;
    logic [1:0]          u2_cur;
    logic [1:0]          u2_next;
    logic [1:0]          lk_val;
    logic                run;
    logic                unused_pc;

    assign run       = (state_q == S_RUN);
    assign unused_pc = ^{lookup_pc, upd_pc};

`ifdef GSHARE_EN
    logic [IDX_BITS-1:0] ghr;

    // Global history shifts in each outcome accepted into U1.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            ghr <= '0;
        else if (run && upd_valid)
            ghr <= {ghr[IDX_BITS-2:0], upd_taken};
    end

    assign lk_idx = lookup_pc[PC_LSB+IDX_BITS-1:PC_LSB] ^ ghr;
    assign up_idx = upd_pc[PC_LSB+IDX_BITS-1:PC_LSB] ^ ghr;
`else
    assign lk_idx = lookup_pc[PC_LSB+IDX_BITS-1:PC_LSB];
    assign up_idx = upd_pc[PC_LSB+IDX_BITS-1:PC_LSB];
`endif

    // State register and init pointer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_INIT;
            init_ptr <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == S_INIT)
                init_ptr <= init_ptr + IDX_BITS'(1);
        end
    end

    // Next state: leave INIT after the last entry is written.
    always_comb begin
        state_d = state_q;
        ready   = 1'b0;
        case (state_q)
            S_INIT: if (&init_ptr) state_d = S_RUN;
            S_RUN:  ready = 1'b1;
            default: state_d = S_INIT;
        endcase
    end

    // U2 read and saturating step; table write lands at end of cycle,
    // so a back-to-back U2 to the same entry reads the fresh value.
    always_comb begin
        u2_cur  = cnt_tbl[u1_idx];
        u2_next = u2_cur;
        if (u1_taken) begin
            if (u2_cur != 2'b11)
                u2_next = u2_cur + 2'd1;
        end else begin
            if (u2_cur != 2'b00)
                u2_next = u2_cur - 2'd1;
        end
    end

    // Lookup read with write-first bypass from the U2 write.
    always_comb begin
        lk_val = cnt_tbl[lk_idx];
        if (u1_valid && (u1_idx == lk_idx))
            lk_val = u2_next;
    end

    // Counter storage: init fill, then U2 writes.
    always_ff @(posedge clk) begin
        if (state_q == S_INIT)
            cnt_tbl[init_ptr] <= INIT_VAL;
        else if (u1_valid)
            cnt_tbl[u1_idx] <= u2_next;
    end

    // U1 stage register; reset drops any in-flight update.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            u1_valid <= 1'b0;
            u1_taken <= 1'b0;
            u1_idx   <= '0;
        end else begin
            u1_valid <= run && upd_valid;
            if (run && upd_valid) begin
                u1_taken <= upd_taken;
                u1_idx   <= up_idx;
            end
        end
    end

    // Prediction register; direction holds when no request.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pred_valid <= 1'b0;
            pred_taken <= 1'b0;
        end else begin
            pred_valid <= run && lookup_valid;
            if (run && lookup_valid)
                pred_taken <= lk_val[1];
        end
    end

endmodule
